// File: rtl/uart_transmitter_if.sv
// Processor-side write interface of the UART transmitter: byte, frame config, load strobe and status.
// The master drives the byte and configuration; the transmitter (slave) returns busy and tx_done.
interface uart_transmitter_if;
  logic [7:0] data_out;
  logic       write_nios;
  logic [1:0] data_bits;
  logic       use_parity;
  logic       parity_type;
  logic       busy;
  logic       tx_done;

  modport master (
    output data_out, write_nios, data_bits, use_parity, parity_type,
    input  busy, tx_done
  );

  modport slave (
    input  data_out, write_nios, data_bits, use_parity, parity_type,
    output busy, tx_done
  );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 5-8 data bits LSB-first, optional even/odd parity, 1 stop; self-timed from clk.
// Optional feature macro UART_TX_CTS_EN adds the cts_n input and a WAIT_CTS state ahead of START.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_transmitter_if.slave    bus,
  output logic                 serial_out
`ifdef UART_TX_CTS_EN
  ,
  input  logic                 cts_n
`endif
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4
`ifdef UART_TX_CTS_EN
    ,
    ST_WAIT_CTS = 3'd5
`endif
  } state_t;

  function automatic logic [7:0] data_mask(input logic [1:0] bits);
    logic [7:0] mask;
    case (bits)
      2'b00:   mask = 8'hFF;
      2'b01:   mask = 8'h7F;
      2'b10:   mask = 8'h3F;
      2'b11:   mask = 8'h1F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  // Even parity is the XOR of the sent bits; odd parity inverts it.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] bits,
                                      input logic odd);
    return (^(data & data_mask(bits))) ^ odd;
  endfunction

  function automatic logic [2:0] last_index(input logic [1:0] bits);
    return 3'd7 - {1'b0, bits};
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       idx_r, idx_s;
  logic [7:0]       shadow_data_r;
  logic [1:0]       shadow_bits_r;
  logic             shadow_par_en_r;
  logic             shadow_odd_r;
  logic             accept_s;
  logic             bit_end_s;
  logic             line_s;
  logic             tx_done_s;
  logic             serial_r;
  logic             busy_r;
  logic             tx_done_r;

  // Next-state, baud counter and bit index; the counter restarts on every state change.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r + CNT_ONE;
    idx_s     = idx_r;
    accept_s  = 1'b0;
    bit_end_s = (cnt_r == CNT_LAST);
    case (state_r)
      ST_IDLE: begin
        cnt_s = CNT_ZERO;
        idx_s = 3'd0;
        if (bus.write_nios) begin
          accept_s = 1'b1;
`ifdef UART_TX_CTS_EN
          if (!cts_n) begin
            state_s = ST_START;
          end else begin
            state_s = ST_WAIT_CTS;
          end
`else
          state_s = ST_START;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
`ifdef UART_TX_CTS_EN
      ST_WAIT_CTS: begin
        cnt_s = CNT_ZERO;
        if (!cts_n) begin
          state_s = ST_START;
        end else begin
          state_s = ST_WAIT_CTS;
        end
      end
`endif
      ST_START: begin
        if (bit_end_s) begin
          state_s = ST_DATA;
          cnt_s   = CNT_ZERO;
          idx_s   = 3'd0;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cnt_s = CNT_ZERO;
          if (idx_r == last_index(shadow_bits_r)) begin
            idx_s   = 3'd0;
            state_s = shadow_par_en_r ? ST_PARITY : ST_STOP;
          end else begin
            idx_s   = idx_r + 3'd1;
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_s = ST_STOP;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
        idx_s   = 3'd0;
      end
    endcase
  end

  // Line level and done pulse for the upcoming cycle, so the outputs can be registered.
  always_comb begin
    line_s    = 1'b1;
    tx_done_s = (state_s == ST_STOP) && (cnt_s == CNT_LAST);
    case (state_s)
      ST_START:  line_s = 1'b0;
      ST_DATA:   line_s = shadow_data_r[idx_s];
      ST_PARITY: line_s = parity_bit(shadow_data_r, shadow_bits_r, shadow_odd_r);
      default:   line_s = 1'b1;
    endcase
  end

  // FSM state, baud counter and bit index registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= 3'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
    end
  end

  // Shadow copy of the byte and frame config, captured only on an accepted write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_data_r   <= 8'h00;
      shadow_bits_r   <= 2'b00;
      shadow_par_en_r <= 1'b0;
      shadow_odd_r    <= 1'b0;
    end else if (accept_s) begin
      shadow_data_r   <= bus.data_out;
      shadow_bits_r   <= bus.data_bits;
      shadow_par_en_r <= bus.use_parity;
      shadow_odd_r    <= bus.parity_type;
    end
  end

  // Registered outputs keep the TX line glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      serial_r  <= 1'b1;
      busy_r    <= 1'b0;
      tx_done_r <= 1'b0;
    end else begin
      serial_r  <= line_s;
      busy_r    <= (state_s != ST_IDLE);
      tx_done_r <= tx_done_s;
    end
  end

  assign serial_out  = serial_r;
  assign bus.busy    = busy_r;
  assign bus.tx_done = tx_done_r;

endmodule
